mcwcs_loader: RTL and testbench

Writable-control-store loader for the M4 microcode memory: the write-side counterpart of the microcode ROM read port. It accepts 16-bit words from a host register interface, assembles them into 56-bit microinstructions, and writes them into a single-port control-store BRAM with an auto-incrementing address. It holds the CPU microsequencer while loading and can optionally read back each written location to verify it.

---
 rtl/mcwcs_pkg.sv | 55 +++++
 rtl/mcwcs_loader_if.sv | 29 ++
 rtl/mcwcs_asm.sv | 55 +++++
 rtl/mcwcs_loader.sv | 167 ++++++++++++++++
 tb/tb_mcwcs_loader.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcwcs_pkg.sv
// mcwcs_pkg: shared types and constants for the M4 writable control store loader.
// The optional read-back verify path is enabled by defining MCWCS_VERIFY_EN.
package mcwcs_pkg;

  localparam int unsigned MC_AW_DEF = 10;
  localparam int unsigned MC_DW_DEF = 56;
  localparam int unsigned HST_W     = 16;
  localparam int unsigned PH_W      = 2;
  localparam int unsigned ST_ADDR_W = 10;

  // status word bit positions
  localparam int unsigned ST_ERR   = 15;
  localparam int unsigned ST_OVF   = 14;
  localparam int unsigned ST_LOAD  = 13;
  localparam int unsigned ST_PH_HI = 12;
  localparam int unsigned ST_PH_LO = 11;

  // control word bit positions
  localparam int unsigned CT_LOAD = 15;
  localparam int unsigned CT_CLR  = 14;

  // last host word of a microinstruction
  localparam logic [PH_W-1:0] PH_LAST = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_VRD   = 2'd2,
    S_VCMP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                 err;
    logic                 ovf;
    logic                 load;
    logic [PH_W-1:0]      phase;
    logic                 rsvd;
    logic [ST_ADDR_W-1:0] addr;
  } status_t;

  // Assemble the host-visible status word.
  function automatic status_t mk_status(input logic err, input logic ovf, input logic load,
                                        input logic [PH_W-1:0] phase,
                                        input logic [ST_ADDR_W-1:0] addr);
    status_t s;
    s.err   = err;
    s.ovf   = ovf;
    s.load  = load;
    s.phase = phase;
    s.rsvd  = 1'b0;
    s.addr  = addr;
    return s;
  endfunction

endpackage

// File: rtl/mcwcs_loader_if.sv
// mcwcs_loader_if: host register port and control-store BRAM port of the loader.
// The slave modport is the loader; the master modport is the host/BRAM side.
interface mcwcs_loader_if #(
  parameter int unsigned MC_AW = 10,
  parameter int unsigned MC_DW = 56
);

  logic             hst_wr;
  logic             hst_sel;
  logic [15:0]      hst_din;
  logic             hst_rdy;
  logic [15:0]      hst_dout;
  logic             ram_ena;
  logic             ram_we;
  logic [MC_AW-1:0] ram_addr;
  logic [MC_DW-1:0] ram_din;
  logic [MC_DW-1:0] ram_dout;

  modport master (
    output hst_wr, hst_sel, hst_din, ram_dout,
    input  hst_rdy, hst_dout, ram_ena, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  hst_wr, hst_sel, hst_din, ram_dout,
    output hst_rdy, hst_dout, ram_ena, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/mcwcs_asm.sv
// mcwcs_asm: collects four 16-bit host words into one microinstruction.
// word_c is the next value of the holding register so the caller can forward
// the completed word in the same cycle the last host word is accepted.
module mcwcs_asm
  import mcwcs_pkg::*;
#(
  parameter int unsigned MC_DW = MC_DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [HST_W-1:0] din,
  output logic [PH_W-1:0]  phase,
  output logic             last_c,
  output logic [MC_DW-1:0] word,
  output logic [MC_DW-1:0] word_c
);

  localparam int unsigned TOP_W = MC_DW - 48;

  logic [PH_W-1:0] phase_d;

  // Next phase / holding word; clear wins and discards any partial word.
  always_comb begin
    phase_d = phase;
    word_c  = word;
    if (clr) begin
      phase_d = '0;
      word_c  = '0;
    end else if (wr) begin
      unique case (phase)
        2'd0: word_c[15:0]        = din;
        2'd1: word_c[31:16]       = din;
        2'd2: word_c[47:32]       = din;
        2'd3: word_c[MC_DW-1:48]  = din[TOP_W-1:0];
      endcase
      if (phase != PH_LAST) phase_d = phase + PH_W'(1);
    end
  end

  assign last_c = wr && !clr && (phase == PH_LAST);

  // Phase counter and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      word  <= '0;
    end else begin
      phase <= phase_d;
      word  <= word_c;
    end
  end

endmodule

// File: rtl/mcwcs_loader.sv
// mcwcs_loader: writable control store loader for the M4 microcode memory.
// Define MCWCS_VERIFY_EN to read back and compare each written location.
module mcwcs_loader
  import mcwcs_pkg::*;
#(
  parameter int unsigned MC_AW = MC_AW_DEF,
  parameter int unsigned MC_DW = MC_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mcwcs_loader_if.slave bus,
  output logic          cpu_hold
);

  state_e           state_q, state_d;
  logic [MC_AW-1:0] addr_q, addr_d;
  logic             load_q, load_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             rdy_q, rdy_d;
  logic             ena_q, ena_d;
  logic             we_q, we_d;
  logic [MC_AW-1:0] raddr_q, raddr_d;
  logic [MC_DW-1:0] rdin_q, rdin_d;
  status_t          dout_q;
  logic             hold_q;

  logic             acc_c, ctl_wr_c, dat_wr_c, done_c, asm_clr_c, last_c;
  logic [PH_W-1:0]  phase_q;
  logic [MC_DW-1:0] word_q, word_c;

  // Host handshake decode.
  assign acc_c    = bus.hst_wr && rdy_q;
  assign ctl_wr_c = acc_c && !bus.hst_sel;
  assign dat_wr_c = acc_c && bus.hst_sel && load_q;

`ifdef MCWCS_VERIFY_EN
  assign done_c = (state_q == S_VCMP);
`else
  assign done_c = (state_q == S_WRITE);
  logic unused_vfy;
  assign unused_vfy = ^{bus.ram_dout, word_q};
`endif

  assign asm_clr_c = ctl_wr_c || done_c;

  mcwcs_asm #(.MC_DW(MC_DW)) u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (asm_clr_c),
    .wr     (dat_wr_c),
    .din    (bus.hst_din),
    .phase  (phase_q),
    .last_c (last_c),
    .word   (word_q),
    .word_c (word_c)
  );

  // Next state, address/status flags and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    load_d  = load_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    rdy_d   = 1'b0;
    ena_d   = 1'b0;
    we_d    = 1'b0;
    raddr_d = raddr_q;
    rdin_d  = rdin_q;

    unique case (state_q)
      S_IDLE: begin
        if (ctl_wr_c) begin
          load_d = bus.hst_din[CT_LOAD];
          addr_d = bus.hst_din[MC_AW-1:0];
          if (bus.hst_din[CT_CLR]) begin
            ovf_d = 1'b0;
            err_d = 1'b0;
          end
        end
        if (last_c) state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef MCWCS_VERIFY_EN
        state_d = S_VRD;
`else
        state_d = S_IDLE;
`endif
      end
      S_VRD: state_d = S_VCMP;
      S_VCMP: begin
`ifdef MCWCS_VERIFY_EN
        if (bus.ram_dout != word_q) err_d = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Post-increment after each completed microinstruction; wrap is sticky.
    if (done_c) begin
      addr_d = addr_q + MC_AW'(1);
      if (addr_q == '1) ovf_d = 1'b1;
    end

    unique case (state_d)
      S_IDLE: rdy_d = 1'b1;
      S_WRITE: begin
        ena_d   = 1'b1;
        we_d    = 1'b1;
        raddr_d = addr_q;
        rdin_d  = word_c;
      end
      S_VRD: begin
        ena_d   = 1'b1;
        raddr_d = addr_q;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Address, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      load_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
      ena_q   <= 1'b0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      rdin_q  <= '0;
      dout_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      load_q  <= load_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      ena_q   <= ena_d;
      we_q    <= we_d;
      raddr_q <= raddr_d;
      rdin_q  <= rdin_d;
      dout_q  <= mk_status(err_q, ovf_q, load_q, phase_q, ST_ADDR_W'(addr_q));
      hold_q  <= load_q;
    end
  end

  assign bus.hst_rdy  = rdy_q;
  assign bus.hst_dout = 16'(dout_q);
  assign bus.ram_ena  = ena_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = raddr_q;
  assign bus.ram_din  = rdin_q;
  assign cpu_hold     = hold_q;

endmodule

// File: tb/tb_mcwcs_loader.sv
// tb_mcwcs_loader: randomized bench for mcwcs_loader with a transaction-level
// model (word queue, address, sticky flags, busy countdown) and a BRAM model.
module tb_mcwcs_loader;
  import mcwcs_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 56;
`ifdef MCWCS_VERIFY_EN
  localparam int BUSY = 3;
  localparam bit VFY  = 1'b1;
`else
  localparam int BUSY = 1;
  localparam bit VFY  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_hold;

  mcwcs_loader_if #(.MC_AW(AW), .MC_DW(DW)) bus ();

  mcwcs_loader #(.MC_AW(AW), .MC_DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_load, m_ovf, m_err;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_words[$];
  int            m_busy = 0;
  longint        cyc = 0;
  longint        we_cyc = -10;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic [15:0]   exp_dout;
  logic          exp_hold;
  logic [DW-1:0] corrupt = '0;

  function automatic logic [15:0] m_status();
    int unsigned ph;
    ph = (m_words.size() > 3) ? 3 : m_words.size();
    return {m_err, m_ovf, m_load, 2'(ph), 1'b0, m_addr};
  endfunction

  task automatic model_reset();
    m_load = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_addr = '0;
    m_words.delete();
    m_busy = 0; we_cyc = -10;
    exp_dout = '0; exp_hold = 1'b0;
  endtask

  task automatic model_complete();
    if (m_addr == '1) m_ovf = 1'b1;
    m_addr = m_addr + AW'(1);
    if (VFY && corrupt != '0) m_err = 1'b1;
    m_words.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        logic [63:0] w64;
        cyc++;
        exp_dout = m_status();
        exp_hold = m_load;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) model_complete();
        end else if (bus.hst_wr) begin
          if (!bus.hst_sel) begin
            m_load = bus.hst_din[15];
            if (bus.hst_din[14]) begin m_ovf = 1'b0; m_err = 1'b0; end
            m_addr = bus.hst_din[AW-1:0];
            m_words.delete();
          end else if (m_load) begin
            m_words.push_back(bus.hst_din);
            if (m_words.size() == 4) begin
              w64 = {m_words[3], m_words[2], m_words[1], m_words[0]};
              exp_wdata = DW'(w64);
              exp_waddr = m_addr;
              we_cyc = cyc;
              m_busy = BUSY;
            end
          end
        end
      end
    end
  end

  // ---------------- BRAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    bus.ram_dout = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_ena) begin
        if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
        else            bus.ram_dout <= mem[bus.ram_addr] ^ corrupt;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic [AW-1:0] cap_addrs[$];
  int            n_we = 0;

  initial begin : cmp
    logic e_we, e_ena;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        e_we  = (cyc == we_cyc);
        e_ena = e_we || (VFY && (cyc == we_cyc + 1));
        chk("hst_rdy", bus.hst_rdy, m_busy == 0);
        chk("ram_we", bus.ram_we, e_we);
        chk("ram_ena", bus.ram_ena, e_ena);
        if (e_ena) chk("ram_addr", bus.ram_addr, exp_waddr);
        if (e_we) chk("ram_din", bus.ram_din, exp_wdata);
        chk("hst_dout", bus.hst_dout, exp_dout);
        chk("cpu_hold", cpu_hold, exp_hold);
        if (bus.ram_we) begin
          cap_addr = bus.ram_addr;
          cap_data = bus.ram_din;
          cap_addrs.push_back(bus.ram_addr);
          n_we++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic hw(input logic sel, input logic [15:0] d);
    int n;
    n = 0;
    while (m_busy != 0) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        n_chk++; n_fail++;
        $display("FAIL rdy_wait: busy=%0d did not clear within 20 cycles", m_busy);
        return;
      end
    end
    bus.hst_wr = 1'b1; bus.hst_sel = sel; bus.hst_din = d;
    @(negedge clk);
    bus.hst_wr = 1'b0;
  endtask

  task automatic uword(input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3);
    hw(1'b1, w0); hw(1'b1, w1); hw(1'b1, w2); hw(1'b1, w3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure_busy(input string name);
    int lo;
    lo = 0;
    while (!bus.hst_rdy && lo < 10) begin lo++; @(negedge clk); end
    chk(name, lo, BUSY);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, bus.hst_rdy, 1'b1);
    chk({tag, "_dout"}, bus.hst_dout, 16'h0000);
    chk({tag, "_ena"}, bus.ram_ena, 1'b0);
    chk({tag, "_we"}, bus.ram_we, 1'b0);
    chk({tag, "_addr"}, bus.ram_addr, '0);
    chk({tag, "_din"}, bus.ram_din, '0);
    chk({tag, "_hold"}, cpu_hold, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0, r;
    logic [AW-1:0] a;
    logic [15:0] c;
    logic b_load, b_clr;
    bus.hst_wr = 1'b0; bus.hst_sel = 1'b0; bus.hst_din = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1; chk_en = 1'b1;
    idle(1);

    // one microinstruction at address 5
    hw(1'b0, 16'h8005);
    uword(16'h1111, 16'h2222, 16'h3333, 16'h00AB);
    measure_busy("t1_busy");
    idle(3);
    chk("t1_addr", cap_addr, 5);
    chk("t1_data", cap_data, 56'hAB333322221111);
    chk("t1_model", exp_wdata, 56'hAB333322221111);
    chk("t1_status", bus.hst_dout, 16'h2006);
    chk("t1_hold", cpu_hold, 1'b1);

    // wrap from 1023 to 0 sets ovf; C000 clears it
    hw(1'b0, 16'h83FF);
    uword(16'hA001, 16'hA002, 16'hA003, 16'h0011);
    uword(16'hB001, 16'hB002, 16'hB003, 16'h0022);
    idle(4);
    chk("t2_addr_a", cap_addrs[cap_addrs.size()-2], 10'd1023);
    chk("t2_addr_b", cap_addrs[cap_addrs.size()-1], 10'd0);
    chk("t2_ovf", bus.hst_dout[ST_OVF], 1'b1);
    chk("t2_status", bus.hst_dout, 16'h6001);
    hw(1'b0, 16'hC000);
    idle(2);
    chk("t2_clr", bus.hst_dout, 16'h2000);

    // partial word discarded by a control write
    hw(1'b1, 16'hDEAD); hw(1'b1, 16'hBEEF);
    n0 = n_we;
    hw(1'b0, 16'h8010);
    uword(16'h0101, 16'h0202, 16'h0303, 16'h0044);
    idle(4);
    chk("t3_count", n_we - n0, 1);
    chk("t3_addr", cap_addr, 10'h010);
    chk("t3_data", cap_data, 56'h44030302020101);

    // data writes with load=0 are ignored
    hw(1'b0, 16'h0020);
    idle(2);
    n0 = n_we;
    for (int i = 0; i < 6; i++) hw(1'b1, 16'(16'h1234 + i));
    idle(2);
    chk("t4_count", n_we - n0, 0);
    chk("t4_status", bus.hst_dout, 16'h0020);
    chk("t4_rdy", bus.hst_rdy, 1'b1);
    chk("t4_hold", cpu_hold, 1'b0);

`ifdef MCWCS_VERIFY_EN
    // read-back mismatch on bit 40 sets err
    hw(1'b0, 16'h8030);
    corrupt = DW'(1) << 40;
    uword(16'h5555, 16'h6666, 16'h7777, 16'h0088);
    measure_busy("v_busy");
    idle(3);
    chk("v_err", bus.hst_dout[ST_ERR], 1'b1);
    chk("v_status", bus.hst_dout, 16'hA031);
    corrupt = '0;
    hw(1'b0, 16'hC030);
    idle(2);
    chk("v_clr", bus.hst_dout, 16'h2030);
`endif

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        hw(1'b1, 16'($urandom));
      end else if (r < 82) begin
        a = (r < 76) ? AW'($urandom_range(1018, 1023)) : AW'($urandom);
        b_load = ($urandom_range(0, 7) != 0);
        b_clr  = ($urandom_range(0, 3) == 0);
        c = {b_load, b_clr, 4'($urandom), 10'(a)};
        hw(1'b0, c);
      end else if (r < 90) begin
        if (VFY && m_busy == 0)
          corrupt = ($urandom_range(0, 1) == 1) ? (DW'(1) << $urandom_range(0, DW-1)) : '0;
      end else begin
        idle(int'($urandom_range(1, 3)));
      end
    end
    idle(6);
    corrupt = '0;

    // asynchronous reset while a write is in flight
    hw(1'b0, 16'h8040);
    uword(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h000D);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("areset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("ar_status", bus.hst_dout, 16'h0000);
    hw(1'b0, 16'h8001);
    uword(16'h1234, 16'h5678, 16'h9ABC, 16'h00EF);
    idle(4);
    chk("ar_addr", cap_addr, 10'd1);
    chk("ar_data", cap_data, 56'hEF9ABC56781234);
    chk("ar_status2", bus.hst_dout, 16'h2002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
